// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - data-memory request/response bundle between controller and responder
interface dmem_responder_if #(
    parameter int DATA_W = 64
);
    logic              DMemRead;
    logic              DMemWrite;
    logic [63:0]       Address;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic              MemReady;
    logic              MemErr;
    logic              MemBusy;

    modport master (
        output DMemRead, DMemWrite, Address, WriteData,
        input  ReadData, MemReady, MemErr, MemBusy
    );

    modport slave (
        input  DMemRead, DMemWrite, Address, WriteData,
        output ReadData, MemReady, MemErr, MemBusy
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding ld/sd responder with wait states and internal storage
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int DATA_W      = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int ADDR_LSB = 3;
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_write;
    logic              r_err;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_req;
    logic w_err;

    // Request decode; the checks are ordered conflict, misalignment, range but all map to one reject
    always_comb begin
        w_req = bus.DMemRead | bus.DMemWrite;
        w_err = 1'b0;
        if (bus.DMemRead && bus.DMemWrite) begin
            w_err = 1'b1;
        end else if (bus.Address[ADDR_LSB-1:0] != '0) begin
            w_err = 1'b1;
        end else if (bus.Address[63:ADDR_LSB] >= (64-ADDR_LSB)'(DEPTH)) begin
            w_err = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; rejects skip straight to the response cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_err) begin
                        w_next = S_RESP;
                    end else if (WAIT_CYCLES > 0) begin
                        w_next = S_WAIT;
                    end else begin
                        w_next = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request latch, wait counter and read-data register; inputs are only looked at in IDLE
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_write <= bus.DMemWrite;
                        r_err   <= w_err;
                        r_idx   <= bus.Address[ADDR_LSB +: IDX_W];
                        r_wdata <= bus.WriteData;
                        r_cnt   <= CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (!r_write) begin
                        r_rdata <= r_mem[r_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage write at the ACCESS exit edge; never cleared, and suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (reset && (r_state == S_ACCESS) && r_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign bus.ReadData = r_rdata;
    assign bus.MemReady = (r_state == S_RESP);
    assign bus.MemErr   = (r_state == S_RESP) && r_err;
    assign bus.MemBusy  = (r_state != S_IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_responder_if #(.DATA_W(64)) bus0 ();
    dmem_responder_if #(.DATA_W(64)) bus1 ();

    dmem_responder #(.DEPTH(256), .DATA_W(64), .WAIT_CYCLES(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    dmem_responder #(.DEPTH(256), .DATA_W(64), .WAIT_CYCLES(0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] ref_mem [int];
    logic [63:0] ref_rd [2];
    logic [63:0] rand_addrs [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int u, input bit rd, input bit wr, input logic [63:0] a, input logic [63:0] d);
        if (u == 0) begin
            bus0.DMemRead = rd; bus0.DMemWrite = wr; bus0.Address = a; bus0.WriteData = d;
        end else begin
            bus1.DMemRead = rd; bus1.DMemWrite = wr; bus1.Address = a; bus1.WriteData = d;
        end
    endtask

    task automatic sample(input int u, output logic rdy, output logic er, output logic bsy, output logic [63:0] rdv);
        if (u == 0) begin
            rdy = bus0.MemReady; er = bus0.MemErr; bsy = bus0.MemBusy; rdv = bus0.ReadData;
        end else begin
            rdy = bus1.MemReady; er = bus1.MemErr; bsy = bus1.MemBusy; rdv = bus1.ReadData;
        end
    endtask

    // One request from an IDLE cycle, held until MemReady; returns one cycle after the response
    task automatic txn(input int u, input bit rd, input bit wr, input logic [63:0] a,
                       input logic [63:0] d, input bit scramble, input string tag);
        int   wc;
        int   lat;
        bit   exp_err;
        int   exp_lat;
        int   key;
        logic rdy, er, bsy;
        logic [63:0] rdv;
        wc      = (u == 0) ? 2 : 0;
        lat     = -1;
        exp_err = (rd && wr) || (a[2:0] != 3'd0) || (a[63:3] >= 61'd256);
        exp_lat = exp_err ? 1 : wc + 2;
        drive(u, rd, wr, a, d);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            sample(u, rdy, er, bsy, rdv);
            if (n == 1) check({tag, " busy"}, 64'(bsy), 64'd1);
            if (rdy) begin
                lat = n;
                break;
            end
            if (scramble) drive(u, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                {$urandom, $urandom}, {$urandom, $urandom});
        end
        drive(u, 1'b0, 1'b0, 64'd0, 64'd0);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        if (lat > 0) begin
            check({tag, " err"}, 64'(er), 64'(exp_err));
            if (!exp_err) begin
                key = u * 1024 + int'(a[10:3]);
                if (wr) ref_mem[key] = d;
                else if (ref_mem.exists(key)) ref_rd[u] = ref_mem[key];
            end
            check({tag, " rdata"}, rdv, ref_rd[u]);
        end
        @(negedge clk);
        sample(u, rdy, er, bsy, rdv);
        check({tag, " single pulse"}, 64'(rdy), 64'd0);
        check({tag, " idle"}, 64'(bsy), 64'd0);
    endtask

    initial begin
        logic rdy, er, bsy;
        logic [63:0] rdv;
        int k;
        logic [63:0] a;

        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        ref_rd[0] = 64'd0;
        ref_rd[1] = 64'd0;
        repeat (2) @(negedge clk);
        sample(0, rdy, er, bsy, rdv);
        check("reset busy", 64'(bsy), 64'd0);
        check("reset ready", 64'(rdy), 64'd0);
        check("reset err", 64'(er), 64'd0);
        check("reset rdata", rdv, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        txn(0, 1'b0, 1'b1, 64'h10, 64'hDEADBEEFCAFEF00D, 1'b0, "wr 0x10");
        txn(0, 1'b1, 1'b0, 64'h10, 64'd0, 1'b0, "rd 0x10");
        check("rd 0x10 value", bus0.ReadData, 64'hDEADBEEFCAFEF00D);

        txn(0, 1'b0, 1'b1, 64'h13, 64'h1111, 1'b0, "misaligned");
        txn(0, 1'b1, 1'b0, 64'h800, 64'd0, 1'b0, "out of range");
        txn(0, 1'b1, 1'b1, 64'h10, 64'h2222, 1'b0, "rd+wr");
        check("rdata after errors", bus0.ReadData, 64'hDEADBEEFCAFEF00D);
        txn(0, 1'b1, 1'b0, 64'h10, 64'd0, 1'b0, "rd 0x10 after errors");

        txn(0, 1'b0, 1'b1, 64'h18, 64'h0123456789ABCDEF, 1'b1, "wr 0x18 scrambled");
        txn(0, 1'b1, 1'b0, 64'h18, 64'd0, 1'b1, "rd 0x18 scrambled");

        txn(0, 1'b0, 1'b1, 64'h20, 64'hAAAA5555AAAA5555, 1'b0, "wr 0x20");
        drive(0, 1'b0, 1'b1, 64'h20, 64'hBADBADBADBADBAD0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample(0, rdy, er, bsy, rdv);
            check("aborted no ready", 64'(rdy), 64'd0);
        end
        reset = 1'b1;
        ref_rd[0] = 64'd0;
        ref_rd[1] = 64'd0;
        check("rdata cleared by reset", bus0.ReadData, 64'd0);
        txn(0, 1'b1, 1'b0, 64'h20, 64'd0, 1'b0, "rd 0x20 after abort");
        check("0x20 keeps old data", bus0.ReadData, 64'hAAAA5555AAAA5555);

        txn(1, 1'b0, 1'b1, 64'h0, 64'h0F0F0F0F0F0F0F0F, 1'b0, "w0 wr 0x0");
        txn(1, 1'b0, 1'b1, 64'h8, 64'h8888777766665555, 1'b0, "w0 wr 0x8");
        txn(1, 1'b1, 1'b0, 64'h0, 64'd0, 1'b0, "w0 rd 0x0");
        txn(1, 1'b1, 1'b0, 64'h8, 64'd0, 1'b0, "w0 rd 0x8");

        for (int i = 0; i < 8; i++) begin
            rand_addrs[i] = 64'(($urandom_range(0, 255)) * 8);
            txn(0, 1'b0, 1'b1, rand_addrs[i], {$urandom, $urandom}, 1'b0, "prefill");
        end
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 9));
            a = rand_addrs[$urandom_range(0, 7)];
            if (k <= 3)      txn(0, 1'b0, 1'b1, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), "rand wr");
            else if (k <= 7) txn(0, 1'b1, 1'b0, a, 64'd0, 1'($urandom_range(0, 1)), "rand rd");
            else if (k == 8) txn(0, 1'b1, 1'b0, a | 64'($urandom_range(1, 7)), 64'd0, 1'b0, "rand misaligned");
            else             txn(0, 1'b0, 1'b1, 64'h800 + 64'($urandom_range(0, 1000) * 8), 64'd1, 1'b0, "rand oor");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the data-memory interface driven by the multicycle control FSM's DMemRead/DMemWrite flags.
- Accepts one doubleword (ld/sd) request at a time and services it after a configurable number of wait states.
- Returns one-cycle MemReady/MemErr completion so the controller can hold in MEM_ACC states until the access finishes.
- Sits between the control/datapath and the data storage array, which is internal to this block.

Parameters:
DEPTH, 256, number of 64-bit words in storage; word index = Address[ADDR_LSB+:log2(DEPTH)] with ADDR_LSB=3
DATA_W, 64, data width in bits; fixed for ld/sd
WAIT_CYCLES, 2, wait-state cycles between request acceptance and the access cycle; 0 is legal

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
DMemRead  in  1  read request, sampled only in IDLE
DMemWrite  in  1  write request, sampled only in IDLE
Address  in  64  byte address, captured with the request
WriteData  in  DATA_W  store data, captured with the request
ReadData  out  DATA_W  read result; valid when MemReady=1 for a successful read
MemReady  out  1  one-cycle completion pulse
MemErr  out  1  qualifies MemReady; 1 = request rejected
MemBusy  out  1  high in every state except IDLE

Behaviour:
- Reset: when reset==0 at a rising edge, the following take effect:
  - state=IDLE, wait counter=0, ReadData=0, MemReady=0, MemErr=0, MemBusy=0.
  - Storage contents are not cleared.
- States are IDLE, WAIT, ACCESS and RESP.
- IDLE, request present (DMemRead|DMemWrite): latch op, Address and WriteData. Next state:
  - error (see below) -> RESP with MemErr pending.
  - WAIT_CYCLES>0 -> WAIT, counter loaded with WAIT_CYCLES-1.
  - WAIT_CYCLES=0 -> ACCESS.
- IDLE, no request: stay in IDLE.
- Error conditions, checked in this order:
  - DMemRead and DMemWrite both high.
  - Address[2:0] != 0 (misaligned).
  - Address[63:3] >= DEPTH (out of range).
- WAIT: counter decrements each cycle; go to ACCESS on the cycle the counter is 0.
- ACCESS, read: ReadData <= mem[idx] at the exit edge.
- ACCESS, write: mem[idx] <= latched WriteData at the exit edge.
- ACCESS always exits to RESP.
- RESP:
  - MemReady=1 for exactly one cycle; MemErr=1 only for a rejected request.
  - Next state is IDLE; a new request is sampled no earlier than the cycle after RESP.
- Latency, with the request first high in cycle 0:
  - Accepted request: MemReady in cycle WAIT_CYCLES+2.
  - Rejected request: MemReady in cycle 1.
- While MemBusy=1, request, Address and WriteData inputs are ignored. Only latched values are used, so the controller may change them freely after acceptance.
- ReadData:
  - Updates only on a successful read.
  - Holds its value across writes, errors and idle cycles.
  - Not cleared on error.
- Writes never modify ReadData.
- Error requests perform no storage access.
- Request held high through RESP: the request is re-sampled as a new request in the IDLE cycle after RESP. The controller must drop the request on MemReady to avoid a duplicate access.
- Reset mid-operation:
  - A write whose ACCESS exit edge has not occurred is not committed.
  - Any access already committed persists.
  - No MemReady is produced for the aborted request.
- Read-after-write to the same address returns the new data, since accesses are strictly serialised.

Test Plan:
- Reset, WAIT_CYCLES=2: reset=0 for 2 cycles -> MemBusy=0, MemReady=0, MemErr=0, ReadData=0.
- Write then read: write Address=0x10, WriteData=0xDEADBEEFCAFEF00D in cycle 0, then read Address=0x10 once IDLE -> both MemReady pulses land in cycle 4 after their request, MemErr=0, ReadData=0xDEADBEEFCAFEF00D.
- Errors, each -> MemReady+MemErr=1 in cycle 1, no storage change, ReadData unchanged:
  - Address=0x13 (misaligned).
  - Address=0x800 with DEPTH=256 (out of range).
  - DMemRead=DMemWrite=1.
- Input changes while busy: change Address/WriteData/DMemRead during WAIT -> access uses the values latched in cycle 0; single MemReady.
- Reset during WAIT of a write to 0x20: later read of 0x20 -> returns prior content, not the aborted data; no MemReady for the aborted request.
- WAIT_CYCLES=0: back-to-back reads of 0x0 and 0x8, with each request held until its MemReady -> MemReady in cycles 2 and 5, correct data each time.
